regwrite_arbiter: RTL and testbench
===================================

# regwrite_arbiter

Arbitrates the single integer register-file write port between the in-order pipeline's writeback result and a multi-cycle unit (MDU: multiply/divide) that completes out of band. Sits directly ahead of the register-file write logic in the writeback stage and drives its `wvalid`/`wa`/`wd` inputs. Queues MDU results in a small FIFO, enforces write-after-write ordering against younger pipeline writes, and stalls the pipeline only when an MDU result has waited too long.

## Interface
- `FIFO_DEPTH`, default 2: MDU result queue entries; power of two, at least 2.
- `STARVE_MAX`, default 4: number of consecutive pipeline grants a queued MDU head tolerates before the stall is forced; at least 1.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset; `reset==0` at a rising edge clears all state.
- `pipe_valid`  in  1  pipeline writeback request this cycle.
- `pipe_dst`  in  5  pipeline destination register (`creg_addr_t`).
- `pipe_data`  in  64  pipeline write data (`word_t`).
- `mdu_valid`  in  1  MDU result offered.
- `mdu_dst`  in  5  MDU destination register.
- `mdu_data`  in  64  MDU result data.
- `mdu_ready`  out  1  queue accepts an MDU result this cycle.
- `pipe_stall`  out  1  pipeline write suppressed this cycle; the writeback stage holds its entry and re-presents it.
- `wvalid`  out  1  register-file write enable.
- `wa`  out  5  register-file write address.
- `wd`  out  64  register-file write data.
- `pending`  out  1  at least one valid MDU entry is queued.
- `pending_mask`  out  32  one-hot OR of the destinations of valid queued entries; bit 0 is always 0. Used by the hazard unit.

## Operation
- Enqueue happens on `mdu_valid && mdu_ready`, where `mdu_ready = (count < FIFO_DEPTH)`. There is no pop-through when the queue is full.
- A result with `mdu_dst==0` is accepted and discarded; it is never stored.
- Each entry holds {valid, dst, data}. An invalidated entry still occupies its slot until it reaches the head.
- **Head cleanup:** an invalid head is popped with no port use. At most one pop occurs per cycle.
- A pipeline request is **live** when `pipe_valid && pipe_dst!=0`. A `pipe_dst==0` request never writes and never stalls.
- **Grant rule**, evaluated each cycle:
  - Starving, i.e. head valid and `wait_cnt==STARVE_MAX`: the head writes and is popped. `pipe_stall=1` if the pipeline request is live.
  - Otherwise, live pipeline request: the pipeline writes. If the head is valid, `wait_cnt` increments, saturating at `STARVE_MAX`.
  - Otherwise, head valid: the head writes and is popped.
  - `wait_cnt` clears on every head pop.
- **WAW squash:** pipeline writes are always younger than queued MDU results.
  - On a granted pipeline write to register d, every queued entry with dst d is invalidated.
  - An MDU result entering the queue in the same cycle with dst d is stored invalid.
- Simultaneous enqueue and pop are both performed when `count < FIFO_DEPTH`.
- `wa` and `wd` are 0 whenever `wvalid==0`.

## Timing
- The pipeline path is combinational: `wvalid`/`wa`/`wd` follow the pipe inputs in the same cycle, with zero latency.
- The MDU path: an entry accepted at edge N can write, at the earliest, in the cycle after edge N.
- `pending`, `pending_mask` and `mdu_ready` are functions of registered state only.
- While `reset==0`, outputs are forced: `wvalid=0`, `wa=0`, `wd=0`, `pipe_stall=0`, `mdu_ready=0`, `pending=0`, `pending_mask=0`.
- After reset is released, `mdu_ready=1` from the first cycle. Queued entries are lost on reset, including a reset mid-stall; none are written afterward.
- Worst-case wait for a valid head is `STARVE_MAX` pipeline grants plus 1 cycle.

## Configuration
- `REGWRITE_ARB_STARVE_EN`
  - Defined: the starvation guard and `wait_cnt` are present, as specified above.
  - Undefined: strict pipeline priority. `pipe_stall` is tied to 0, `wait_cnt` is removed, and the MDU head writes only in cycles without a live pipeline request.

## Structure
- `pipes` package gains `regwrite_req_t` {valid, dst `creg_addr_t`, data `word_t`}.
- `creg_addr_t` and `word_t` are taken from `common`.
- Sub-module `regwrite_fifo` provides:
  - circular queue with head/tail pointers and count;
  - per-entry valid bits;
  - match-invalidate port (dst, enable);
  - `pending_mask` generation.
- The arbiter top contains the grant logic, `wait_cnt` and output muxing.

## Test plan
- Pipe-only: `pipe_valid=1`, dst=5, data=0xAA -> same cycle `wvalid=1`, `wa=5`, `wd=0xAA`, `pipe_stall=0`.
- MDU idle path: enqueue dst=7, data=0x1234 at edge N, `pipe_valid=0` -> cycle N+1 `wvalid=1`, `wa=7`; `pending=0` and `pending_mask=0` after edge N+1.
- Starvation (STARVE_MAX=4, macro defined): dst=3 queued, pipeline writes dst 9 every cycle -> 4 pipeline grants, then `pipe_stall=1` with `wa=3`; next cycle the pipeline writes dst 9.
- WAW: queued dst=10, data=1; pipeline writes dst=10, data=2 -> `wa=10`, `wd=2`; `pending_mask[10]=0` next cycle; value 1 is never written.
- Full/x0: depth 2 with the pipeline busy, enqueue two entries -> `mdu_ready=0`. Later, enqueue with `mdu_dst=0` -> accepted, `pending` unchanged, no write.
- Reset mid-operation: two entries queued, `reset=0` for one edge -> all outputs 0 during reset; afterward `pending=0` and no MDU writes.

Source files
------------

// File: rtl/common_pkg.sv
// Shared core-wide scalar types: architectural register address and datapath word.
package common;
   localparam int unsigned NUM_CREGS = 32;
   localparam int unsigned XLEN      = 64;

   typedef logic [$clog2(NUM_CREGS)-1:0] creg_addr_t;
   typedef logic [XLEN-1:0]              word_t;
endpackage : common

// File: rtl/pipes_pkg.sv
// Pipeline transfer records exchanged between stages.
package pipes;
   import common::*;

   typedef struct packed {
      logic       valid;
      creg_addr_t dst;
      word_t      data;
   } regwrite_req_t;
endpackage : pipes

// File: rtl/regwrite_fifo.sv
// Circular queue of pending MDU register writes with per-entry valid bits,
// a match-invalidate port for WAW squashing, and automatic cleanup of invalid heads.
module regwrite_fifo
   import common::*;
   import pipes::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enq_i,
   input  regwrite_req_t enq_req_i,
   input  logic          pop_i,
   input  logic          inv_en_i,
   input  creg_addr_t    inv_dst_i,
   output regwrite_req_t head_o,
   output logic          pop_o,
   output logic          full_o,
   output logic          pending_o,
   output logic [NUM_CREGS-1:0] pending_mask_o
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0]    head_q, tail_q;
   logic [CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   creg_addr_t       dst_q  [DEPTH];
   word_t            data_q [DEPTH];

   // Valid bits are cleared on pop, so slots outside the live window never report as pending.
   assign head_o.valid = valid_q[head_q];
   assign head_o.dst   = dst_q[head_q];
   assign head_o.data  = data_q[head_q];
   assign pop_o        = (count_q != '0) && (pop_i || !valid_q[head_q]);
   assign full_o       = (count_q == CW'(DEPTH));
   assign pending_o    = |valid_q;
   assign count_d      = count_q + CW'(enq_i) - CW'(pop_o);

   // NOTE: every variable in an always_comb gets a default first so no latch is inferred.
   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (inv_en_i && dst_q[i] == inv_dst_i) valid_d[i] = 1'b0;
      end
      if (pop_o) valid_d[head_q] = 1'b0;
      if (enq_i) valid_d[tail_q] = enq_req_i.valid;
   end

   always_comb begin
      pending_mask_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) pending_mask_o[dst_q[i]] = 1'b1;
      end
      pending_mask_o[0] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_q + PW'(pop_o);
         tail_q  <= tail_q + PW'(enq_i);
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // NOTE: payload storage is not reset; the valid bits alone decide whether a slot means anything.
   always_ff @(posedge clk) begin
      if (enq_i) begin
         dst_q[tail_q]  <= enq_req_i.dst;
         data_q[tail_q] <= enq_req_i.data;
      end
   end
endmodule : regwrite_fifo

// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs queued MDU results.
// Build option REGWRITE_ARB_STARVE_EN enables the starvation guard (wait_cnt + pipe_stall).
module regwrite_arbiter
   import common::*;
   import pipes::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pipe_valid,
   input  creg_addr_t           pipe_dst,
   input  word_t                pipe_data,
   input  logic                 mdu_valid,
   input  creg_addr_t           mdu_dst,
   input  word_t                mdu_data,
   output logic                 mdu_ready,
   output logic                 pipe_stall,
   output logic                 wvalid,
   output creg_addr_t           wa,
   output word_t                wd,
   output logic                 pending,
   output logic [NUM_CREGS-1:0] pending_mask
);
   regwrite_req_t        head, enq_req;
   logic                 live, starving, head_grant, pipe_grant;
   logic                 enq, fifo_pop, fifo_full, fifo_pending;
   logic [NUM_CREGS-1:0] fifo_mask;

   assign live      = pipe_valid && (pipe_dst != '0);
   assign mdu_ready = reset && !fifo_full;
   assign enq       = mdu_valid && mdu_ready && (mdu_dst != '0);
   // A same-cycle pipeline write to the same register is younger, so the result arrives dead.
   assign enq_req   = '{valid: !(pipe_grant && pipe_dst == mdu_dst), dst: mdu_dst, data: mdu_data};

   regwrite_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk            (clk),
      .reset          (reset),
      .enq_i          (enq),
      .enq_req_i      (enq_req),
      .pop_i          (head_grant),
      .inv_en_i       (pipe_grant),
      .inv_dst_i      (pipe_dst),
      .head_o         (head),
      .pop_o          (fifo_pop),
      .full_o         (fifo_full),
      .pending_o      (fifo_pending),
      .pending_mask_o (fifo_mask)
   );

`ifdef REGWRITE_ARB_STARVE_EN
   localparam int unsigned WW = $clog2(STARVE_MAX + 1);

   logic [WW-1:0] wait_cnt_q, wait_cnt_d;

   assign starving = head.valid && (wait_cnt_q == WW'(STARVE_MAX));

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (fifo_pop)
         wait_cnt_d = '0;
      else if (pipe_grant && head.valid && wait_cnt_q != WW'(STARVE_MAX))
         wait_cnt_d = wait_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) wait_cnt_q <= '0;
      else        wait_cnt_q <= wait_cnt_d;
   end
`else
   assign starving = 1'b0;
`endif

   always_comb begin
      wvalid     = 1'b0;
      wa         = '0;
      wd         = '0;
      pipe_stall = 1'b0;
      head_grant = 1'b0;
      pipe_grant = 1'b0;
      if (reset) begin
         if (starving) begin
            head_grant = 1'b1;
            pipe_stall = live;
         end else if (live) begin
            pipe_grant = 1'b1;
         end else if (head.valid) begin
            head_grant = 1'b1;
         end
         if (head_grant) begin
            wvalid = 1'b1;
            wa     = head.dst;
            wd     = head.data;
         end else if (pipe_grant) begin
            wvalid = 1'b1;
            wa     = pipe_dst;
            wd     = pipe_data;
         end
      end
   end

   assign pending      = reset && fifo_pending;
   assign pending_mask = reset ? fifo_mask : '0;
endmodule : regwrite_arbiter

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter (FIFO_DEPTH=2, STARVE_MAX=4); follows REGWRITE_ARB_STARVE_EN.
module tb_regwrite_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        pipe_valid, mdu_valid;
   logic [4:0]  pipe_dst, mdu_dst;
   logic [63:0] pipe_data, mdu_data;
   logic        mdu_ready, pipe_stall, wvalid, pending;
   logic [4:0]  wa;
   logic [63:0] wd;
   logic [31:0] pending_mask;

   int compared   = 0;
   int mismatched = 0;

   regwrite_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .pipe_valid   (pipe_valid),
      .pipe_dst     (pipe_dst),
      .pipe_data    (pipe_data),
      .mdu_valid    (mdu_valid),
      .mdu_dst      (mdu_dst),
      .mdu_data     (mdu_data),
      .mdu_ready    (mdu_ready),
      .pipe_stall   (pipe_stall),
      .wvalid       (wvalid),
      .wa           (wa),
      .wd           (wd),
      .pending      (pending),
      .pending_mask (pending_mask)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance past the next rising edge, then apply inputs; outputs are checked 1ns later.
   task automatic step(input logic pv, input logic [4:0] pd, input logic [63:0] pdat,
                       input logic mv, input logic [4:0] md, input logic [63:0] mdat);
      @(posedge clk);
      #1;
      pipe_valid = pv; pipe_dst = pd; pipe_data = pdat;
      mdu_valid  = mv; mdu_dst  = md; mdu_data  = mdat;
      #1;
   endtask

   task automatic check_write(input string tag, input logic v, input logic [4:0] a, input logic [63:0] d);
      check({tag, ".wvalid"}, 64'(wvalid), 64'(v));
      check({tag, ".wa"},     64'(wa),     64'(a));
      check({tag, ".wd"},     wd,          d);
   endtask

   initial begin
      reset = 1'b0;
      pipe_valid = 1'b0; pipe_dst = '0; pipe_data = '0;
      mdu_valid  = 1'b0; mdu_dst  = '0; mdu_data  = '0;

      // Held in reset with requests present: everything forced low.
      step(1, 5'd5, 64'hAA, 1, 5'd14, 64'hE);
      check_write("rst", 0, 0, 0);
      check("rst.stall", 64'(pipe_stall), 0);
      check("rst.ready", 64'(mdu_ready), 0);
      check("rst.pending", 64'(pending), 0);
      check("rst.mask", 64'(pending_mask), 0);

      // Pipe-only, first cycle out of reset.
      @(posedge clk); #1;
      reset = 1'b1;
      pipe_valid = 1; pipe_dst = 5'd5; pipe_data = 64'hAA;
      mdu_valid = 0; mdu_dst = 0; mdu_data = 0;
      #1;
      check_write("pipe", 1, 5, 64'hAA);
      check("pipe.stall", 64'(pipe_stall), 0);
      check("pipe.ready", 64'(mdu_ready), 1);
      check("pipe.pending", 64'(pending), 0);

      // x0 pipeline request: no write, no stall.
      step(1, 5'd0, 64'h55, 0, 0, 0);
      check_write("px0", 0, 0, 0);

      // MDU idle path: accept at edge N, write in cycle N+1, drained after N+1.
      step(0, 0, 0, 1, 5'd7, 64'h1234);
      check_write("mdu.enq", 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check("mdu.pending", 64'(pending), 1);
      check("mdu.mask", 64'(pending_mask), 64'h80);
      check_write("mdu.wr", 1, 7, 64'h1234);
      step(0, 0, 0, 0, 0, 0);
      check("mdu.pending0", 64'(pending), 0);
      check("mdu.mask0", 64'(pending_mask), 0);
      check_write("mdu.idle", 0, 0, 0);

      // Starvation: dst 3 queued, pipeline hammering dst 9.
      step(0, 0, 0, 1, 5'd3, 64'h33);
      for (int i = 0; i < 4; i++) begin
         step(1, 5'd9, 64'h99, 0, 0, 0);
         check_write($sformatf("starve.g%0d", i), 1, 9, 64'h99);
         check($sformatf("starve.s%0d", i), 64'(pipe_stall), 0);
      end
      step(1, 5'd9, 64'h99, 0, 0, 0);
`ifdef REGWRITE_ARB_STARVE_EN
      check("starve.stall", 64'(pipe_stall), 1);
      check_write("starve.head", 1, 3, 64'h33);
      step(1, 5'd9, 64'h99, 0, 0, 0);
      check("starve.after.stall", 64'(pipe_stall), 0);
      check_write("starve.after", 1, 9, 64'h99);
      check("starve.after.pending", 64'(pending), 0);
`else
      check("prio.stall", 64'(pipe_stall), 0);
      check_write("prio.pipe", 1, 9, 64'h99);
      check("prio.pending", 64'(pending), 1);
      step(0, 0, 0, 0, 0, 0);
      check_write("prio.head", 1, 3, 64'h33);
`endif
      step(0, 0, 0, 0, 0, 0);
      check_write("starve.idle", 0, 0, 0);

      // WAW: queued dst 10 data 1, then pipeline writes dst 10 data 2.
      step(1, 5'd9, 64'h99, 1, 5'd10, 64'h1);
      check_write("waw.busy", 1, 9, 64'h99);
      step(1, 5'd10, 64'h2, 0, 0, 0);
      check_write("waw.pipe", 1, 10, 64'h2);
      check("waw.mask.before", 64'(pending_mask), 64'h400);
      step(0, 0, 0, 0, 0, 0);
      check("waw.mask.after", 64'(pending_mask), 0);
      check("waw.pending", 64'(pending), 0);
      check_write("waw.noold", 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check_write("waw.noold2", 0, 0, 0);

      // Same-cycle squash: pipeline and MDU both target x12.
      step(1, 5'd12, 64'h5, 1, 5'd12, 64'h6);
      check_write("samecyc.pipe", 1, 12, 64'h5);
      step(0, 0, 0, 0, 0, 0);
      check("samecyc.pending", 64'(pending), 0);
      check_write("samecyc.none", 0, 0, 0);

      // Full: two entries with the pipeline busy, third refused.
      step(1, 5'd9, 64'h99, 1, 5'd4, 64'h44);
      check("full.r0", 64'(mdu_ready), 1);
      step(1, 5'd9, 64'h99, 1, 5'd6, 64'h66);
      check("full.r1", 64'(mdu_ready), 1);
      step(1, 5'd9, 64'h99, 1, 5'd8, 64'h88);
      check("full.r2", 64'(mdu_ready), 0);
      check("full.mask", 64'(pending_mask), 64'h50);
      step(0, 0, 0, 0, 0, 0);
      check_write("full.h4", 1, 4, 64'h44);
      // x0 result: accepted, discarded.
      step(0, 0, 0, 1, 5'd0, 64'hFF);
      check("x0.ready", 64'(mdu_ready), 1);
      check("x0.pending", 64'(pending), 1);
      check_write("x0.h6", 1, 6, 64'h66);
      step(0, 0, 0, 0, 0, 0);
      check("x0.pending.after", 64'(pending), 0);
      check("x0.mask.after", 64'(pending_mask), 0);
      check_write("x0.nowrite", 0, 0, 0);

      // Reset mid-operation with two entries queued.
      step(1, 5'd9, 64'h99, 1, 5'd11, 64'hB);
      step(1, 5'd9, 64'h99, 1, 5'd13, 64'hD);
      check("midrst.mask", 64'(pending_mask), 64'h800);
      @(posedge clk); #1;
      reset = 1'b0;
      pipe_valid = 1; pipe_dst = 5'd9; mdu_valid = 1; mdu_dst = 5'd14;
      #1;
      check_write("midrst.force", 0, 0, 0);
      check("midrst.stall", 64'(pipe_stall), 0);
      check("midrst.ready", 64'(mdu_ready), 0);
      check("midrst.pending", 64'(pending), 0);
      check("midrst.mask0", 64'(pending_mask), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      pipe_valid = 0; mdu_valid = 0;
      #1;
      check("post.pending", 64'(pending), 0);
      check("post.ready", 64'(mdu_ready), 1);
      check_write("post.w0", 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check_write("post.w1", 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check_write("post.w2", 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule : tb_regwrite_arbiter
